bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (iterative shift-and-add-3, "double dabble"). It is the reverse of the elevator's BCD-to-binary path: it takes a binary floor/count value from the controller and produces packed 4-bit BCD digits for the seven-segment display drivers. It uses a start/busy/done handshake and needs BIN_W+1 cycles per conversion.

Parameters:
BIN_W, 14, width of the binary input; legal range 1..(3*DIGITS+3).
DIGITS, 4, number of BCD digits presented at bcd_out.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE or DONE
bin_in  input  BIN_W  binary value; captured on the edge where start is accepted
bcd_out  output  4*DIGITS  packed BCD; most significant digit in the top nibble, least significant in [3:0]
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  one-cycle pulse; bcd_out/overflow are valid from this cycle on
overflow  output  1  bin_in exceeded 10^DIGITS-1; bcd_out saturated

Behaviour:
- Reset, at any time including mid-conversion: state=IDLE, bcd_out=0, busy=0, done=0, overflow=0, internal shift register and counter cleared. No done pulse follows an aborted conversion.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at edge N, capture bin_in into the binary shift field, clear the internal BCD field (DIGITS+1 digits), set counter=0, go to SHIFT. busy=1 from edge N.
- SHIFT: one step per edge. First add 3 to each internal BCD digit that is >=5 (all digits in parallel). Then shift the {bcd, bin} register left by 1. counter increments.
- The step at edge N+BIN_W is the last one. On that edge go to DONE and register the outputs: busy=0, done=1, bcd_out and overflow updated.
- Output rule: if the extra (DIGITS+1)th internal digit is non-zero, then overflow=1 and every bcd_out digit is 9. Otherwise overflow=0 and bcd_out takes the low DIGITS digits.
- DONE lasts exactly one cycle, so done is high during the cycle after edge N+BIN_W.
  - With start=1 in DONE, the new conversion is accepted exactly as from IDLE (back-to-back). A new conversion runs every BIN_W+1 cycles.
  - Otherwise go to IDLE.
- start while in SHIFT is ignored, with no queuing. bin_in changes during SHIFT have no effect.
- bcd_out/overflow hold their last values through IDLE and through the next SHIFT. They change only on the DONE-entry edge (or on rst).
- Latency: start accepted at edge N, results and done visible after edge N+BIN_W. That is BIN_W+1 cycles edge-to-edge including the capture edge.
- Width rule: the internal register is (DIGITS+1)*4+BIN_W bits. The legal BIN_W bound guarantees that no intermediate value is lost.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), BCD_DIGIT_W=4, and the constant BCD_NINE=4'd9. The display drivers use the same constants.
- One natural sub-module: bcd_add3. It is combinational, 4-bit in and 4-bit out, returning in+3 when in>=5 and in otherwise. It is instantiated DIGITS+1 times with generate.
- The FSM, counter and shift register stay in bin_to_bcd_seq.

Test Plan:
- rst, then start with bin_in=0 -> done pulses exactly 15 cycles after the start edge; bcd_out=16'h0000, overflow=0, busy high for 14 cycles.
- bin_in=1234, then 9999, then 7 (all digit boundaries) -> bcd_out=16'h1234, 16'h9999, 16'h0007 in turn, overflow=0 each time.
- bin_in=10000 and bin_in=16383 -> bcd_out=16'h9999, overflow=1. A following bin_in=42 -> 16'h0042, overflow=0.
- start asserted continuously with bin_in changing every cycle -> conversions accepted only on IDLE/DONE edges, one result every 15 cycles. Each result matches the bin_in captured at its start edge.
- Pulse start again 5 cycles into a conversion of 500 -> ignored; a single done with 16'h0500.
- Assert rst 7 cycles into a conversion of 321 -> busy=0, bcd_out=0 the next cycle and no done. A fresh start with 321 then yields 16'h0321.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared state encoding and BCD constants for the converter and display drivers
package bin_to_bcd_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_if: start/busy/done handshake and data bus between controller and converter
interface bin_to_bcd_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                          start;
    logic [BIN_W-1:0]              bin_in;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          busy;
    logic                          done;
    logic                          overflow;
    modport master (output start, bin_in, input bcd_out, busy, done, overflow);
    modport slave  (input start, bin_in, output bcd_out, busy, done, overflow);
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig,
    output logic [BCD_DIGIT_W-1:0] adj
);
    assign adj = (dig >= 4'd5) ? dig + 4'd3 : dig;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-and-add-3 binary to packed BCD converter, BIN_W+1 cycles per conversion
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
)(
    input  logic         clk,
    input  logic         rst,
    bin_to_bcd_if.slave  bus
);
    localparam int BCD_W = (DIGITS + 1) * BCD_DIGIT_W;
    localparam int REG_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int OUT_W = DIGITS * BCD_DIGIT_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [REG_W-1:0]   sr, sr_add, sr_step;
    logic [OUT_W-1:0]   bcd_q;
    logic               ovf_q, accept, last;

    // One extra guard digit catches values above 10^DIGITS-1
    for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .dig (sr[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .adj (sr_add[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end
    assign sr_add[BIN_W-1:0] = sr[BIN_W-1:0];
    assign sr_step = {sr_add[REG_W-2:0], 1'b0};

    always_comb begin
        accept    = (state != SHIFT) && bus.start;
        last      = (state == SHIFT) && (cnt == CNT_W'(BIN_W - 1));
        state_nxt = accept ? SHIFT : last ? DONE : (state == SHIFT) ? SHIFT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            sr  <= {{BCD_W{1'b0}}, bus.bin_in};
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr_step;
            cnt <= cnt + 1'b1;
            if (last) begin
                ovf_q <= |sr_step[REG_W-1 -: BCD_DIGIT_W];
                bcd_q <= |sr_step[REG_W-1 -: BCD_DIGIT_W] ? {DIGITS{BCD_NINE}}
                                                          : sr_step[BIN_W +: OUT_W];
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
endmodule
